mux_skid_stage: RTL
===================

// Module: mux_skid_stage
// PURPOSE
//  Parametrised N:1 datapath selector followed by a 2-entry skid buffer with
//  valid/ready handshake. It replaces bare combinational 2:1 selects at pipeline
//  boundaries, for example PC-source and forwarding selection feeding a stage
//  register. Back-pressure and flushes are absorbed without a combinational
//  ready path. Out-of-range selects are flagged and travel with the data.
// PARAMETERS
//  WIDTH  32  data width of each input channel and of the output
//  N      2   number of input channels (>=2)
//  SELW   $clog2(N)  select width (derived; do not override)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  in_data    in   N*WIDTH   channel k at bits [k*WIDTH +: WIDTH]
//  sel        in   SELW      channel index, sampled with in_valid
//  in_valid   in   1         upstream offers a transfer
//  in_ready   out  1         stage can accept; registered, no path from out_ready
//  flush      in   1         drop all buffered entries
//  out_data   out  WIDTH     head entry data
//  out_err    out  1         head entry had sel >= N
//  out_valid  out  1         head entry present
//  out_ready  in   1         downstream accepts head
// BEHAVIOUR
//  - One clock; all state updates on posedge clk.
//  - Reset values are 0 for out_valid, out_data, out_err and the skid entry.
//  - in_ready resets to 1.
//  - Priority order is rst, then flush, then normal operation.
//  - Accept: in_valid & in_ready. The captured word is in_data[sel*WIDTH +: WIDTH].
//  - Out-of-range select: if sel >= N, the captured word is all-zero and the
//    entry's err bit is 1.
//  - Pop: out_valid & out_ready.
//  - Storage is the main register (drives the outputs) and a skid register.
//  - in_ready = ~skid_valid, held in a register.
//  - Latency: an accept in cycle t makes out_valid=1 in cycle t+1 when main
//    was empty or popped in cycle t.
//  - Throughput is 1 word/cycle while out_ready=1.
//  - Per-cycle update rules:
//    - main empty or popped, skid empty: accept loads main; otherwise main is
//      emptied on pop.
//    - main full, not popped, accept: the word goes to skid; in_ready drops next
//      cycle.
//    - skid full and pop: skid moves to main, skid is emptied, in_ready rises
//      next cycle. No accept is possible in this cycle.
//  - Ordering is strict FIFO and no word is duplicated or lost.
//  - Held output: while out_valid=1 and out_ready=0, out_data and out_err are
//    stable.
//  - flush: next cycle out_valid=0, skid empty, in_ready=1. A same-cycle accept
//    or pop is discarded. Data registers may keep stale values.
//  - rst mid-operation behaves the same as flush, and the data registers are
//    also cleared.
//  - sel is don't-care when in_valid=0. Unknown sel on accept gives X data
//    (simulation only).
// TESTING
//  - Reset: rst=1 for 2 cycles, then release -> out_valid=0, out_data=0,
//    out_err=0, in_ready=1.
//  - Streaming: N=4, in_data={D,C,B,A}, sel=0,1,2,3 on consecutive cycles,
//    out_ready=1 -> out_data is A,B,C,D one cycle later each, with no bubbles.
//  - Back-pressure: out_ready=0, push 0x11 then 0x22 -> in_ready=0 after the
//    2nd accept. Then out_ready=1 -> 0x11, 0x22 in order, and in_ready=1 again.
//  - Bad select: N=3, sel=3 with in_valid=1 -> out_data=0 and out_err=1 for
//    that word only.
//  - Flush, full case: flush with both entries full and in_valid=1 -> next
//    cycle out_valid=0, in_ready=1, and none of the three words ever appears.
//  - Simultaneous pop and accept with main full and skid empty -> the new word
//    replaces main with no skid use.
//  - Scoreboard: randomised valid/ready over 10k cycles -> output sequence
//    equals the accepted sequence.

Source files
------------

// File: rtl/mux_skid_stage.sv
// N:1 channel select feeding a 2-entry skid buffer with valid/ready handshake.
// The main entry drives the outputs, and the skid entry absorbs one word of back-pressure.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   in_data [N*WIDTH]   channel k at bits [k*WIDTH +: WIDTH]
//   sel                 channel index, sampled on accept
//   in_valid/in_ready   upstream handshake (in_ready is a register)
//   flush               drop all buffered entries
//   out_data/out_err    head entry data and out-of-range-select flag
//   out_valid/out_ready downstream handshake
module mux_skid_stage #(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             skid_valid;

    logic [WIDTH-1:0] pick_data;
    logic             pick_err;
    logic             accept;
    logic             pop;

    // Select is widened by one bit so that the comparison with N cannot wrap.
    always_comb begin
        pick_err  = ({1'b0, sel} >= (SELW+1)'(N));
        pick_data = '0;
        if (!pick_err)
            pick_data = in_data[sel*WIDTH +: WIDTH];
    end

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (skid_valid) begin
            // in_ready is low here, so no accept can collide with the refill.
            if (pop) begin
                out_data   <= skid_data;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end
        end else if (!out_valid || pop) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= pick_data;
                out_err  <= pick_err;
            end
        end else if (accept) begin
            skid_data  <= pick_data;
            skid_err   <= pick_err;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

endmodule
